// File: rtl/mem_stage.sv
// Memory stage of the 5-stage LoongArch pipeline: holds one instruction, waits for
// its data-RAM response, aligns/extends load data, and drives writeback and the decode bypass.
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 75,
    parameter int MS_TO_WS_BUS_WD = 70,
    parameter int MS_FWD_BUS_WD   = 39
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [MS_FWD_BUS_WD-1:0]   ms_fwd_bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] LD_W  = 3'b000;
    localparam logic [2:0] LD_B  = 3'b001;
    localparam logic [2:0] LD_H  = 3'b010;
    localparam logic [2:0] LD_BU = 3'b011;
    localparam logic [2:0] LD_HU = 3'b100;

    logic                       r_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] r_bus;
    state_t                     r_state;
    logic [31:0]                r_rdata_buf;

    state_t      w_state_next;
    logic        w_buf_load;
    logic        w_ready_go;
    logic        w_es_mem_op;
    logic [2:0]  w_ld_type;
    logic        w_store_op;
    logic        w_load_op;
    logic        w_mem_op;
    logic        w_gr_we;
    logic [4:0]  w_dest;
    logic [31:0] w_exe_result;
    logic [31:0] w_pc;
    logic [1:0]  w_off;
    logic [31:0] w_ld_src;
    logic [7:0]  w_bytes [4];
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ld_data;
    logic [31:0] w_final_result;
    logic        w_fwd_valid;
    logic        w_fwd_block;

    assign w_ld_type    = r_bus[74:72];
    assign w_store_op   = r_bus[71];
    assign w_load_op    = r_bus[70];
    assign w_gr_we      = r_bus[69];
    assign w_dest       = r_bus[68:64];
    assign w_exe_result = r_bus[63:32];
    assign w_pc         = r_bus[31:0];
    assign w_mem_op     = w_load_op | w_store_op;
    assign w_es_mem_op  = es_to_ms_bus[71] | es_to_ms_bus[70];

    assign w_ready_go     = !w_mem_op
                          | ((r_state == ST_WAIT) & data_sram_data_ok)
                          | (r_state == ST_DONE);
    assign ms_allowin     = !r_ms_valid | (w_ready_go & ws_allowin);
    assign ms_to_ws_valid = r_ms_valid & w_ready_go;

    // Leaving the stage (ms_allowin) always resets the FSM for whatever enters next.
    always_comb begin
        w_state_next = r_state;
        w_buf_load   = 1'b0;
        if (ms_allowin) begin
            w_state_next = (es_to_ms_valid & w_es_mem_op) ? ST_WAIT : ST_IDLE;
        end else if (r_ms_valid && (r_state == ST_WAIT) && data_sram_data_ok) begin
            w_state_next = ST_DONE;
            w_buf_load   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ms_valid  <= 1'b0;
            r_state     <= ST_IDLE;
            r_rdata_buf <= 32'd0;
        end else begin
            r_state <= w_state_next;
            if (ms_allowin) begin
                r_ms_valid <= es_to_ms_valid;
            end
            if (w_buf_load) begin
                r_rdata_buf <= data_sram_rdata;
            end
        end
    end

    // Loaded on bubbles too; contents are meaningless while r_ms_valid is low.
    always_ff @(posedge clk) begin
        if (ms_allowin) begin
            r_bus <= es_to_ms_bus;
        end
    end

    assign w_ld_src = (r_state == ST_DONE) ? r_rdata_buf : data_sram_rdata;
    assign w_off    = w_exe_result[1:0];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte_lane
            assign w_bytes[gi] = w_ld_src[gi*8 +: 8];
        end
    endgenerate

    assign w_byte = w_bytes[w_off];
    assign w_half = w_off[1] ? w_ld_src[31:16] : w_ld_src[15:0];

    always_comb begin
        w_ld_data = w_ld_src;
        case (w_ld_type)
            LD_W:    w_ld_data = w_ld_src;
            LD_B:    w_ld_data = {{24{w_byte[7]}}, w_byte};
            LD_BU:   w_ld_data = {24'd0, w_byte};
            LD_H:    w_ld_data = {{16{w_half[15]}}, w_half};
            LD_HU:   w_ld_data = {16'd0, w_half};
            default: w_ld_data = w_ld_src;
        endcase
    end

    assign w_final_result = w_load_op ? w_ld_data : w_exe_result;

    assign ms_to_ws_bus = {w_gr_we, w_dest, w_final_result, w_pc};

    assign w_fwd_valid = r_ms_valid & w_gr_we & (w_dest != 5'd0);
    assign w_fwd_block = w_fwd_valid & w_load_op & !w_ready_go;
    assign ms_fwd_bus  = {w_fwd_valid, w_fwd_block, w_dest, w_final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus random traffic, all checked against a
// transaction-level model (instruction held / response received / aligned result).
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [74:0] es_to_ms_bus;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [38:0] ms_fwd_bus;

    mem_stage #(
        .ES_TO_MS_BUS_WD(75),
        .MS_TO_WS_BUS_WD(70),
        .MS_FWD_BUS_WD  (39)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .ws_allowin       (ws_allowin),
        .ms_allowin       (ms_allowin),
        .es_to_ms_valid   (es_to_ms_valid),
        .es_to_ms_bus     (es_to_ms_bus),
        .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata  (data_sram_rdata),
        .ms_to_ws_valid   (ms_to_ws_valid),
        .ms_to_ws_bus     (ms_to_ws_bus),
        .ms_fwd_bus       (ms_fwd_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model of the instruction currently in the stage (m_*) and after the next edge (n_*).
    logic        m_valid, m_got, n_valid, n_got;
    logic [74:0] m_bus, n_bus;
    logic [31:0] m_data, n_data;
    logic        g_accepted;
    logic [31:0] g_final;

    task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [74:0] mk(input logic [2:0] t, input logic st, input logic ld,
                                       input logic we, input logic [4:0] dest,
                                       input logic [31:0] res, input logic [31:0] pc);
        return {t, st, ld, we, dest, res, pc};
    endfunction

    // Load result from the raw word, by arithmetic on byte/halfword positions.
    function automatic logic [31:0] ref_load(input logic [2:0] t, input logic [1:0] off,
                                             input logic [31:0] d);
        logic [31:0] b;
        logic [31:0] h;
        b = (d >> (8 * int'(off))) & 32'hFF;
        h = (d >> (16 * int'(off[1]))) & 32'hFFFF;
        case (t)
            3'd1:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
            3'd3:    return b;
            3'd2:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3'd4:    return h;
            default: return d;
        endcase
    endfunction

    task automatic cycle(input logic rst, input logic esv, input logic [74:0] bus,
                         input logic ws, input logic dok, input logic [31:0] rd);
        logic is_ld, is_mem, resp_now, ready, exp_allow, exp_out, fv, fb;
        logic [31:0] fin;
        @(posedge clk);
        m_valid = n_valid; m_bus = n_bus; m_got = n_got; m_data = n_data;
        #1;
        reset = rst; es_to_ms_valid = esv; es_to_ms_bus = bus; ws_allowin = ws;
        data_sram_data_ok = dok; data_sram_rdata = rd;
        #1;
        is_ld     = m_bus[70];
        is_mem    = m_bus[70] | m_bus[71];
        resp_now  = m_valid && is_mem && !m_got && dok;
        ready     = !is_mem || m_got || resp_now;
        fin       = is_ld ? ref_load(m_bus[74:72], m_bus[33:32], m_got ? m_data : rd)
                          : m_bus[63:32];
        exp_allow = !m_valid || (ready && ws);
        exp_out   = m_valid && ready;
        fv        = m_valid && m_bus[69] && (m_bus[68:64] != 5'd0);
        fb        = fv && is_ld && !ready;
        check("allowin",   70'(ms_allowin),     70'(exp_allow));
        check("out_valid", 70'(ms_to_ws_valid), 70'(exp_out));
        check("fwd_valid", 70'(ms_fwd_bus[38]), 70'(fv));
        check("fwd_block", 70'(ms_fwd_bus[37]), 70'(fb));
        if (exp_out) begin
            check("ws_bus",     ms_to_ws_bus, {m_bus[69], m_bus[68:64], fin, m_bus[31:0]});
            check("fwd_result", 70'(ms_fwd_bus[36:0]), 70'({m_bus[68:64], fin}));
            if (ws && !rst)
                $display("XFER pc=%h we=%0d dest=%0d result=%h", m_bus[31:0], m_bus[69],
                         m_bus[68:64], fin);
        end
        g_final    = fin;
        g_accepted = exp_allow && esv && !rst;
        if (rst) begin
            n_valid = 1'b0; n_got = 1'b0;
        end else if (exp_allow) begin
            n_valid = esv; n_bus = bus; n_got = 1'b0;
        end else if (resp_now) begin
            n_got = 1'b1; n_data = rd;
        end
    endtask

    localparam logic [74:0] NOP = 75'd0;

    logic [2:0]  t2_type [4] = '{3'd1, 3'd3, 3'd2, 3'd4};
    logic [31:0] t2_addr [4] = '{32'h1003, 32'h1003, 32'h1002, 32'h1002};
    logic [31:0] t2_exp  [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF};

    initial begin
        logic [74:0] rbus;
        logic        rdok;
        int          lat;
        int          kind;

        reset = 1'b1; ws_allowin = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0;
        data_sram_data_ok = 1'b0; data_sram_rdata = '0;
        n_valid = 1'b0; n_got = 1'b0; n_bus = '0; n_data = '0;
        repeat (3) @(posedge clk);

        // Reset state
        cycle(0, 0, NOP, 1, 0, 32'h0);
        check("rst_allowin", 70'(ms_allowin), 70'd1);
        check("rst_valid",   70'(ms_to_ws_valid), 70'd0);
        check("rst_fwd",     70'(ms_fwd_bus[38:37]), 70'd0);

        // 1: ALU op passes in one cycle
        cycle(0, 1, mk(3'd0, 0, 0, 1, 5'd5, 32'h1234_5678, 32'h1C00_0000), 1, 0, 32'h0);
        cycle(0, 0, NOP, 1, 0, 32'h0);
        check("t1_valid",  70'(ms_to_ws_valid), 70'd1);
        check("t1_result", 70'(ms_to_ws_bus[63:32]), 70'h1234_5678);
        check("t1_fwd",    70'(ms_fwd_bus[38:37]), 70'b10);

        // 2: sub-word loads with data_ok in the first MEM cycle
        cycle(0, 1, mk(t2_type[0], 0, 1, 1, 5'd6, t2_addr[0], 32'h1C00_0010), 1, 0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, i < 3,
                  (i < 3) ? mk(t2_type[(i+1)%4], 0, 1, 1, 5'd6, t2_addr[(i+1)%4], 32'h1C00_0014 + 32'(4*i)) : NOP,
                  1, 1, 32'h80FF_0011);
            check("t2_valid",  70'(ms_to_ws_valid), 70'd1);
            check("t2_result", 70'(ms_to_ws_bus[63:32]), 70'(t2_exp[i]));
        end

        // 3: ld.w with a 3-cycle response delay
        cycle(0, 1, mk(3'd0, 0, 1, 1, 5'd7, 32'h2000, 32'h1C00_0100), 1, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, NOP, 1, 0, $urandom);
            check("t3_stall_valid", 70'(ms_to_ws_valid), 70'd0);
            check("t3_stall_block", 70'(ms_fwd_bus[37]), 70'd1);
        end
        cycle(0, 0, NOP, 1, 1, 32'hCAFE_BABE);
        check("t3_result", 70'(ms_to_ws_bus[63:32]), 70'hCAFE_BABE);

        // 4: response arrives while writeback is stalled; buffered word must be held
        cycle(0, 1, mk(3'd0, 0, 1, 1, 5'd8, 32'h2004, 32'h1C00_0200), 1, 0, 32'h0);
        cycle(0, 0, NOP, 0, 1, 32'hCAFE_BABE);
        check("t4_first", 70'(ms_to_ws_bus[63:32]), 70'hCAFE_BABE);
        for (int i = 0; i < 2; i++) begin
            cycle(0, 0, NOP, 0, 0, 32'hDEAD_DEAD);
            check("t4_hold", 70'(ms_to_ws_bus[63:32]), 70'hCAFE_BABE);
        end
        cycle(0, 0, NOP, 1, 0, 32'hDEAD_DEAD);
        check("t4_release", 70'(ms_to_ws_bus[63:32]), 70'hCAFE_BABE);
        cycle(0, 0, NOP, 1, 0, 32'h0);
        check("t4_idle", 70'(ms_to_ws_valid), 70'd0);

        // 5: back-to-back store then load
        cycle(0, 1, mk(3'd0, 1, 0, 0, 5'd9, 32'h3000, 32'h1C00_0300), 1, 0, 32'h0);
        cycle(0, 1, mk(3'd0, 0, 1, 1, 5'd9, 32'h3000, 32'h1C00_0304), 1, 1, 32'h0);
        check("t5_st_we",  70'(ms_to_ws_bus[69]), 70'd0);
        check("t5_st_fwd", 70'(ms_fwd_bus[38]), 70'd0);
        cycle(0, 0, NOP, 1, 1, 32'h55AA_1234);
        check("t5_ld_result", 70'(ms_to_ws_bus[63:32]), 70'h55AA_1234);
        check("t5_ld_pc",     70'(ms_to_ws_bus[31:0]), 70'h1C00_0304);

        // 6: reset while waiting, then a stray data_ok
        cycle(0, 1, mk(3'd0, 0, 1, 1, 5'd10, 32'h4000, 32'h1C00_0400), 1, 0, 32'h0);
        cycle(1, 0, NOP, 1, 0, 32'h0);
        cycle(0, 0, NOP, 1, 1, 32'h1111_2222);
        check("t6_valid",   70'(ms_to_ws_valid), 70'd0);
        check("t6_allowin", 70'(ms_allowin), 70'd1);
        cycle(0, 1, mk(3'd0, 0, 0, 1, 5'd11, 32'h0BAD_F00D, 32'h1C00_0500), 1, 0, 32'h0);
        check("t6_idle_valid", 70'(ms_to_ws_valid), 70'd0);
        cycle(0, 0, NOP, 1, 0, 32'h0);
        check("t6_after", 70'(ms_to_ws_bus[63:32]), 70'h0BAD_F00D);

        // Random traffic with random RAM latency (0..3 cycles) and writeback back-pressure
        lat = 0;
        for (int c = 0; c < 2000; c++) begin
            kind = int'($urandom_range(0, 2));
            rbus = mk(3'($urandom_range(0, 4)), kind == 2, kind == 1,
                      (kind != 2) && ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
                      $urandom, $urandom);
            rdok = n_valid && (n_bus[70] | n_bus[71]) && !n_got && (lat == 0);
            cycle(0, $urandom_range(0, 3) != 0, rbus, $urandom_range(0, 3) != 0, rdok, $urandom);
            if (g_accepted) lat = int'($urandom_range(0, 3));
            else if (!rdok && lat > 0) lat--;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
